// File: rtl/blackjack_pkg.sv
// Shared types and constants for the BlackJack turn sequencer.
// Holds the FSM state encoding, result and player codes, and the scoring helper.
package blackjack_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_DEAL,
    S_P1_TURN,
    S_P2_TURN,
    S_DEALER,
    S_DRAW_WAIT,
    S_DRAW_GAP,
    S_SCORE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_LOSE = 2'd2;
  localparam logic [1:0] RES_PUSH = 2'd3;

  localparam logic [1:0] USER_NONE   = 2'd0;
  localparam logic [1:0] USER_P1     = 2'd1;
  localparam logic [1:0] USER_P2     = 2'd2;
  localparam logic [1:0] USER_DEALER = 2'd3;

  localparam logic [5:0] BUST_LIMIT = 6'd21;
  localparam logic [2:0] DEAL_CARDS = 3'd6;

  // Initial deal goes round the table twice: P1, P2, dealer, P1, P2, dealer.
  function automatic logic [1:0] deal_target(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3: deal_target = USER_P1;
      3'd1, 3'd4: deal_target = USER_P2;
      default:    deal_target = USER_DEALER;
    endcase
  endfunction

  function automatic logic [1:0] score_hand(input logic [5:0] p_best, input logic p_bust,
                                            input logic [5:0] d_best, input logic d_bust);
    if (p_bust)               score_hand = RES_LOSE;
    else if (d_bust)          score_hand = RES_WIN;
    else if (p_best > d_best) score_hand = RES_WIN;
    else if (p_best < d_best) score_hand = RES_LOSE;
    else                      score_hand = RES_PUSH;
  endfunction

endpackage

// File: rtl/hand_evaluator.sv
// Combinational best-total and bust evaluation for one hand.
// Aces count high unless that busts and a low total exists.
module hand_evaluator
  import blackjack_pkg::*;
(
  input  logic [5:0] high,
  input  logic [5:0] low,
  output logic [5:0] best,
  output logic       bust
);

  always_comb begin
    if (high <= BUST_LIMIT)  best = high;
    else if (low != 6'd0)    best = low;
    else                     best = high;
    bust = (best > BUST_LIMIT);
  end

endmodule

// File: rtl/blackjack_sequencer.sv
// Turn-level BlackJack controller: deal, player turns, dealer rule, scoring.
// Hand totals are captured only in the gap cycle after each card is added.
module blackjack_sequencer
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int DRAW_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       cardsUpdated,
  input  logic [5:0] p1_high,
  input  logic [5:0] p1_low,
  input  logic [5:0] p2_high,
  input  logic [5:0] p2_low,
  input  logic [5:0] d_high,
  input  logic [5:0] d_low,
  output logic [1:0] userSelect,
  output logic       clearHands,
  output logic [1:0] turn,
  output logic [1:0] p1_result,
  output logic [1:0] p2_result,
  output logic       gameOver,
  output logic       fault
);

  localparam int         TW          = $clog2(DRAW_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DRAW_TIMEOUT - 1);
  localparam logic [5:0] STAND_TOTAL = 6'(DEALER_STAND);

  state_t          state;
  state_t          ret_state;
  logic [2:0]      deal_cnt;
  logic [TW-1:0]   tmo_cnt;

  // Index 0 = P1, 1 = P2, 2 = dealer.
  logic [5:0] high_in  [3];
  logic [5:0] low_in   [3];
  logic [5:0] high_reg [3];
  logic [5:0] low_reg  [3];
  logic [5:0] best     [3];
  logic       bust     [3];

  assign high_in[0] = p1_high;
  assign high_in[1] = p2_high;
  assign high_in[2] = d_high;
  assign low_in[0]  = p1_low;
  assign low_in[1]  = p2_low;
  assign low_in[2]  = d_low;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_eval
      hand_evaluator u_eval (
        .high (high_reg[gi]),
        .low  (low_reg[gi]),
        .best (best[gi]),
        .bust (bust[gi])
      );
    end
  endgenerate

  logic p1_done;
  logic p2_done;
  assign p1_done = bust[0] || (best[0] == BUST_LIMIT);
  assign p2_done = bust[1] || (best[1] == BUST_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      deal_cnt   <= 3'd0;
      tmo_cnt    <= '0;
      userSelect <= USER_NONE;
      clearHands <= 1'b0;
      turn       <= USER_NONE;
      p1_result  <= RES_NONE;
      p2_result  <= RES_NONE;
      gameOver   <= 1'b0;
      fault      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        high_reg[i] <= 6'd0;
        low_reg[i]  <= 6'd0;
      end
    end else begin
      clearHands <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            state      <= S_CLEAR;
            clearHands <= 1'b1;
            userSelect <= USER_NONE;
            turn       <= USER_NONE;
            p1_result  <= RES_NONE;
            p2_result  <= RES_NONE;
            gameOver   <= 1'b0;
            fault      <= 1'b0;
            deal_cnt   <= 3'd0;
          end
        end

        // The first deal request is issued straight from CLEAR so it
        // appears two cycles after start; DEAL issues the remaining five.
        S_CLEAR: begin
          for (int i = 0; i < 3; i++) begin
            high_reg[i] <= 6'd0;
            low_reg[i]  <= 6'd0;
          end
          userSelect <= deal_target(3'd0);
          deal_cnt   <= 3'd1;
          tmo_cnt    <= '0;
          ret_state  <= S_DEAL;
          state      <= S_DRAW_WAIT;
        end

        S_DEAL: begin
          if (deal_cnt == DEAL_CARDS) begin
            state <= S_P1_TURN;
            turn  <= USER_P1;
          end else begin
            userSelect <= deal_target(deal_cnt);
            deal_cnt   <= deal_cnt + 3'd1;
            tmo_cnt    <= '0;
            ret_state  <= S_DEAL;
            state      <= S_DRAW_WAIT;
          end
        end

        S_P1_TURN: begin
          if (p1_done || stand) begin
            state <= S_P2_TURN;
            turn  <= USER_P2;
          end else if (hit) begin
            userSelect <= USER_P1;
            tmo_cnt    <= '0;
            ret_state  <= S_P1_TURN;
            state      <= S_DRAW_WAIT;
          end
        end

        S_P2_TURN: begin
          if (p2_done || stand) begin
            if (bust[0] && bust[1]) begin
              state <= S_SCORE;
              turn  <= USER_NONE;
            end else begin
              state <= S_DEALER;
              turn  <= USER_DEALER;
            end
          end else if (hit) begin
            userSelect <= USER_P2;
            tmo_cnt    <= '0;
            ret_state  <= S_P2_TURN;
            state      <= S_DRAW_WAIT;
          end
        end

        S_DEALER: begin
          if (best[2] < STAND_TOTAL) begin
            userSelect <= USER_DEALER;
            tmo_cnt    <= '0;
            ret_state  <= S_DEALER;
            state      <= S_DRAW_WAIT;
          end else begin
            state <= S_SCORE;
          end
        end

        S_DRAW_WAIT: begin
          if (cardsUpdated) begin
            userSelect <= USER_NONE;
            state      <= S_DRAW_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            userSelect <= USER_NONE;
            turn       <= USER_NONE;
            fault      <= 1'b1;
            state      <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_DRAW_GAP: begin
          for (int i = 0; i < 3; i++) begin
            high_reg[i] <= high_in[i];
            low_reg[i]  <= low_in[i];
          end
          state <= ret_state;
        end

        S_SCORE: begin
          p1_result <= score_hand(best[0], bust[0], best[2], bust[2]);
          p2_result <= score_hand(best[1], bust[1], best[2], bust[2]);
          turn      <= USER_NONE;
          gameOver  <= 1'b1;
          state     <= S_DONE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_sequencer.sv
// Directed bench for blackjack_sequencer: full games with hand-computed results,
// draw timeout, restart from fault and asynchronous reset mid-draw.
module tb_blackjack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       hit;
  logic       stand;
  logic       cardsUpdated;
  logic [5:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
  logic [1:0] userSelect;
  logic       clearHands;
  logic [1:0] turn;
  logic [1:0] p1_result, p2_result;
  logic       gameOver;
  logic       fault;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  blackjack_sequencer #(.DEALER_STAND(17), .DRAW_TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hit          (hit),
    .stand        (stand),
    .cardsUpdated (cardsUpdated),
    .p1_high      (p1_high),
    .p1_low       (p1_low),
    .p2_high      (p2_high),
    .p2_low       (p2_low),
    .d_high       (d_high),
    .d_low        (d_low),
    .userSelect   (userSelect),
    .clearHands   (clearHands),
    .turn         (turn),
    .p1_result    (p1_result),
    .p2_result    (p2_result),
    .gameOver     (gameOver),
    .fault        (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hands(input logic [5:0] a_h, a_l, b_h, b_l, c_h, c_l);
    p1_high = a_h; p1_low = a_l;
    p2_high = b_h; p2_low = b_l;
    d_high  = c_h; d_low  = c_l;
  endtask

  task automatic wait_request(input logic [1:0] exp, input string tag);
    int n = 0;
    while (userSelect == 2'd0 && n < 100) begin
      tick;
      n++;
    end
    check({tag, "_req"}, userSelect, exp);
  endtask

  // Answer a draw request three cycles later, then expect the gap cycle.
  task automatic serve(input logic [1:0] exp, input string tag);
    wait_request(exp, tag);
    repeat (3) tick;
    check({tag, "_held"}, userSelect, exp);
    cardsUpdated = 1'b1;
    tick;
    cardsUpdated = 1'b0;
    check({tag, "_gap"}, userSelect, 2'd0);
  endtask

  task automatic deal(input string tag);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_user;
      exp_user = 2'((i % 3) + 1);
      serve(exp_user, $sformatf("%s_deal%0d", tag, i));
    end
  endtask

  task automatic wait_turn(input logic [1:0] exp, input string tag);
    int n = 0;
    while (turn != exp && n < 20) begin
      tick;
      n++;
    end
    check(tag, turn, exp);
  endtask

  // Waits for gameOver and records whether any draw request appeared meanwhile.
  task automatic wait_done(input string tag, output logic [1:0] seen_user);
    int n = 0;
    seen_user = 2'd0;
    while (!gameOver && n < 30) begin
      if (userSelect != 2'd0) seen_user = userSelect;
      tick;
      n++;
    end
    check({tag, "_gameover"}, gameOver, 1'b1);
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_clear_pulse"}, clearHands, 1'b1);
    check({tag, "_fault_clr"}, fault, 1'b0);
    tick;
    check({tag, "_clear_end"}, clearHands, 1'b0);
    check({tag, "_first_req"}, userSelect, 2'd1);
  endtask

  initial begin
    logic [1:0] seen;
    int         n;

    reset = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0; cardsUpdated = 1'b0;
    set_hands(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
    repeat (3) tick;
    reset = 1'b0;
    tick;
    check("rst_user", userSelect, 2'd0);
    check("rst_turn", turn, 2'd0);
    check("rst_res", {p1_result, p2_result}, 4'd0);
    check("rst_flags", {clearHands, gameOver, fault}, 3'd0);

    // Game A: P1 19, P2 16, dealer 18; both stand, dealer stays.
    set_hands(6'd19, 6'd0, 6'd16, 6'd0, 6'd18, 6'd0);
    start_game("a");
    deal("a");
    wait_turn(2'd1, "a_turn_p1");
    stand = 1'b1; tick; stand = 1'b0;
    check("a_turn_p2", turn, 2'd2);
    stand = 1'b1; tick; stand = 1'b0;
    check("a_turn_dealer", turn, 2'd3);
    wait_done("a", seen);
    check("a_no_draw", seen, 2'd0);
    check("a_p1_res", p1_result, 2'd1);
    check("a_p2_res", p2_result, 2'd2);
    check("a_turn_none", turn, 2'd0);
    hit = 1'b1; tick; hit = 1'b0;
    check("a_hit_ignored", userSelect, 2'd0);
    check("a_still_over", gameOver, 1'b1);

    // Game B: P1 hits from 12 to 24 and busts; P2 20 pushes dealer 20.
    set_hands(6'd12, 6'd0, 6'd20, 6'd0, 6'd20, 6'd0);
    start_game("b");
    check("b_results_cleared", {p1_result, p2_result, gameOver}, 5'd0);
    deal("b");
    wait_turn(2'd1, "b_turn_p1");
    set_hands(6'd24, 6'd0, 6'd20, 6'd0, 6'd20, 6'd0);
    hit = 1'b1; tick; hit = 1'b0;
    check("b_hit_req", userSelect, 2'd1);
    serve(2'd1, "b_hit");
    wait_turn(2'd2, "b_auto_p2");
    stand = 1'b1; tick; stand = 1'b0;
    check("b_turn_dealer", turn, 2'd3);
    wait_done("b", seen);
    check("b_p1_res", p1_result, 2'd2);
    check("b_p2_res", p2_result, 2'd3);

    // Game C: soft P1 (23/13 -> 13) stays in turn; hit+stand means stand.
    set_hands(6'd23, 6'd13, 6'd17, 6'd0, 6'd17, 6'd0);
    start_game("c");
    deal("c");
    wait_turn(2'd1, "c_turn_p1");
    repeat (3) tick;
    check("c_soft_stays", turn, 2'd1);
    hit = 1'b1; stand = 1'b1; tick; hit = 1'b0; stand = 1'b0;
    check("c_stand_wins", turn, 2'd2);
    check("c_no_draw", userSelect, 2'd0);
    stand = 1'b1; tick; stand = 1'b0;
    check("c_turn_dealer", turn, 2'd3);
    wait_done("c", seen);
    check("c_dealer17_stays", seen, 2'd0);
    check("c_p1_res", p1_result, 2'd2);
    check("c_p2_res", p2_result, 2'd3);

    // Game D: dealer 16 draws to 22 and busts; P1 18 and P2 20 both win.
    set_hands(6'd18, 6'd0, 6'd20, 6'd0, 6'd16, 6'd0);
    start_game("d");
    deal("d");
    wait_turn(2'd1, "d_turn_p1");
    set_hands(6'd18, 6'd0, 6'd20, 6'd0, 6'd22, 6'd0);
    stand = 1'b1; tick; stand = 1'b0;
    stand = 1'b1; tick; stand = 1'b0;
    check("d_turn_dealer", turn, 2'd3);
    serve(2'd3, "d_dealer");
    wait_done("d", seen);
    check("d_p1_res", p1_result, 2'd1);
    check("d_p2_res", p2_result, 2'd1);

    // Game E: first request never answered -> fault after 64 waiting cycles.
    start_game("e");
    n = 0;
    while (!fault && n < 100) begin
      tick;
      n++;
    end
    check("e_fault", fault, 1'b1);
    check("e_timeout_cycles", n, 64);
    check("e_user_dropped", userSelect, 2'd0);
    start_game("e_restart");
    serve(2'd1, "e_d0");
    serve(2'd2, "e_d1");
    wait_request(2'd3, "e_d2");
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    check("e_async_user", userSelect, 2'd0);
    check("e_async_flags", {clearHands, gameOver, fault}, 3'd0);
    check("e_async_turn_res", {turn, p1_result, p2_result}, 6'd0);
    tick;
    reset = 1'b0;
    tick;
    check("e_idle_after_reset", userSelect, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
